uart_flow_echo: RTL and testbench

UART_FLOW_ECHO -- requirements
Module: uart_flow_echo

---
 rtl/uart_flow_echo.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_uart_flow_echo.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_flow_echo.sv
// uart_flow_echo
//   UART echo with a receive FIFO, software flow control (XON/XOFF) and a
//   cork/uncork hold-off. Received bytes are buffered and echoed; when the
//   FIFO fills past XOFF_LEVEL an XOFF is sent, and when it drains to
//   XON_LEVEL an XON follows. A CORK_CHAR byte holds echo output until an
//   UNCORK_CHAR byte arrives.
//
// Ports
//   clock           in   single clock
//   reset           in   asynchronous active-high reset (sync release inside)
//   uart_rx         in   8N1 serial in, asynchronous to clock
//   uart_tx         out  8N1 serial out
//   fill_o          out  FIFO occupancy, DEPTH_BITS+1 bits
//   overflow_o      out  sticky: a received byte was dropped (FIFO full)
//   framing_error_o out  sticky: a received frame had a 0 stop bit
//   led_rx, led_tx  out  stretched activity indicators
module uart_flow_echo #(
  parameter int          CLOCKS_PER_BAUD = 104,
  parameter int          DEPTH_BITS      = 5,
  parameter int          XOFF_LEVEL      = 24,
  parameter int          XON_LEVEL       = 8,
  parameter logic [7:0]  CORK_CHAR       = "e",
  parameter logic [7:0]  UNCORK_CHAR     = "z",
  parameter int          LED_CYCLES      = 600000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic                  uart_tx,
  output logic [DEPTH_BITS:0]   fill_o,
  output logic                  overflow_o,
  output logic                  framing_error_o,
  output logic                  led_rx,
  output logic                  led_tx
);

  localparam int DEPTH = 1 << DEPTH_BITS;
  localparam int HALF  = CLOCKS_PER_BAUD / 2;
  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  localparam int LED_W = $clog2(LED_CYCLES + 1);

  localparam logic [CNT_W-1:0]    BAUD_LAST   = CNT_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [CNT_W-1:0]    BAUD_PENULT = CNT_W'(CLOCKS_PER_BAUD - 2);
  localparam logic [CNT_W-1:0]    HALF_LAST   = CNT_W'(HALF - 1);
  localparam logic [DEPTH_BITS:0] DEPTH_N     = (DEPTH_BITS + 1)'(DEPTH);
  localparam logic [DEPTH_BITS:0] XOFF_N      = (DEPTH_BITS + 1)'(XOFF_LEVEL);
  localparam logic [DEPTH_BITS:0] XON_N       = (DEPTH_BITS + 1)'(XON_LEVEL);
  localparam logic [LED_W-1:0]    LED_LOAD    = LED_W'(LED_CYCLES);
  localparam logic [7:0]          XOFF_CHAR   = 8'h13;
  localparam logic [7:0]          XON_CHAR    = 8'h11;

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;

  // Reset synchroniser: asserts immediately, releases two edges later.
  logic rst_meta_q, rst_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  // RX line synchroniser; idle-high so both stages reset to 1.
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clock or posedge rst_q) begin
    if (rst_q) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // RX state machine
  rx_state_t        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic             rx_valid_q;
  logic             rx_ferr_q;

  always_ff @(posedge clock or posedge rst_q) begin
    if (rst_q) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (!rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_LAST;
          end
        end
        RX_START: begin
          // Mid-start resample: a line already back high was a glitch.
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end else begin
            rx_state_q <= RX_DATA;
            rx_cnt_q   <= BAUD_LAST;
            rx_bit_q   <= '0;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= BAUD_LAST;
            if (rx_bit_q == 3'd7) begin
              rx_state_q <= RX_STOP;
            end else begin
              rx_bit_q <= rx_bit_q + 3'd1;
            end
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != '0) begin
            rx_cnt_q <= rx_cnt_q - 1'b1;
          end else if (rx_sync_q) begin
            rx_valid_q <= 1'b1;
            rx_state_q <= RX_IDLE;
          end else begin
            rx_ferr_q  <= 1'b1;
            rx_state_q <= RX_WAIT;
          end
        end
        RX_WAIT: begin
          // A low stop bit may be a break; hold off until the line recovers.
          if (rx_sync_q) begin
            rx_state_q <= RX_IDLE;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // FIFO storage and arbitration
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   fill_q, fill_d;
  logic                  overflow_q, overflow_d;
  logic                  corked_q, corked_d;
  logic                  xoff_sent_q, xoff_sent_d;
  logic                  xoff_pend_q, xoff_pend_d;
  logic                  xon_pend_q, xon_pend_d;
  logic [LED_W-1:0]      led_rx_cnt_q, led_rx_cnt_d;
  logic [LED_W-1:0]      led_tx_cnt_q, led_tx_cnt_d;

  tx_state_t             tx_state_q;
  logic                  fifo_wr, fifo_rd, tx_idle, send_xoff, send_xon, tx_load;
  logic [7:0]            tx_byte;

  always_comb begin
    fifo_wr   = rx_valid_q && (fill_q < DEPTH_N);
    tx_idle   = (tx_state_q == TX_IDLE);
    // Flow-control characters win arbitration and bypass the cork.
    send_xoff = tx_idle && xoff_pend_q;
    send_xon  = tx_idle && xon_pend_q && !xoff_pend_q;
    fifo_rd   = tx_idle && !xoff_pend_q && !xon_pend_q && !corked_q && (fill_q != '0);
    tx_load   = send_xoff || send_xon || fifo_rd;

    tx_byte = mem[rd_ptr_q];
    if (send_xoff) begin
      tx_byte = XOFF_CHAR;
    end else if (send_xon) begin
      tx_byte = XON_CHAR;
    end

    wr_ptr_d = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

    fill_d = fill_q;
    if (fifo_wr && !fifo_rd) begin
      fill_d = fill_q + 1'b1;
    end else if (fifo_rd && !fifo_wr) begin
      fill_d = fill_q - 1'b1;
    end

    overflow_d = overflow_q || (rx_valid_q && !fifo_wr);

    // Cork state follows every accepted frame, stored or dropped.
    corked_d = corked_q;
    if (rx_valid_q && (rx_shift_q == CORK_CHAR)) begin
      corked_d = 1'b1;
    end else if (rx_valid_q && (rx_shift_q == UNCORK_CHAR)) begin
      corked_d = 1'b0;
    end

    xoff_sent_d = xoff_sent_q;
    if (send_xoff) begin
      xoff_sent_d = 1'b1;
    end else if (send_xon) begin
      xoff_sent_d = 1'b0;
    end

    xoff_pend_d = xoff_pend_q;
    if (send_xoff) begin
      xoff_pend_d = 1'b0;
    end else if ((fill_q >= XOFF_N) && !xoff_sent_q) begin
      xoff_pend_d = 1'b1;
    end

    xon_pend_d = xon_pend_q;
    if (send_xon) begin
      xon_pend_d = 1'b0;
    end else if ((fill_q <= XON_N) && xoff_sent_q) begin
      xon_pend_d = 1'b1;
    end

    led_rx_cnt_d = (led_rx_cnt_q != '0) ? led_rx_cnt_q - 1'b1 : '0;
    if (!rx_sync_q) begin
      led_rx_cnt_d = LED_LOAD;
    end
    led_tx_cnt_d = (led_tx_cnt_q != '0) ? led_tx_cnt_q - 1'b1 : '0;
    if (tx_load) begin
      led_tx_cnt_d = LED_LOAD;
    end
  end

  always_ff @(posedge clock or posedge rst_q) begin
    if (rst_q) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_q       <= '0;
      overflow_q   <= 1'b0;
      corked_q     <= 1'b0;
      xoff_sent_q  <= 1'b0;
      xoff_pend_q  <= 1'b0;
      xon_pend_q   <= 1'b0;
      led_rx_cnt_q <= '0;
      led_tx_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      overflow_q   <= overflow_d;
      corked_q     <= corked_d;
      xoff_sent_q  <= xoff_sent_d;
      xoff_pend_q  <= xoff_pend_d;
      xon_pend_q   <= xon_pend_d;
      led_rx_cnt_q <= led_rx_cnt_d;
      led_tx_cnt_q <= led_tx_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_wr) begin
      mem[wr_ptr_q] <= rx_shift_q;
    end
  end

  // TX state machine
  logic             tx_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [3:0]       tx_bit_q;
  logic [8:0]       tx_shift_q;

  always_ff @(posedge clock or posedge rst_q) begin
    if (rst_q) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_load) begin
            tx_state_q <= TX_BUSY;
            tx_q       <= 1'b0;
            tx_shift_q <= {1'b1, tx_byte};
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
          end
        end
        TX_BUSY: begin
          // Leave one clock early in the stop bit so the idle-state
          // arbitration lands in the stop bit's last clock and the next
          // start bit follows with no gap.
          if ((tx_bit_q == 4'd9) && (tx_cnt_q == BAUD_PENULT)) begin
            tx_state_q <= TX_IDLE;
          end else if (tx_cnt_q == BAUD_LAST) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= tx_bit_q + 4'd1;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b1, tx_shift_q[8:1]};
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign uart_tx         = tx_q;
  assign fill_o          = fill_q;
  assign overflow_o      = overflow_q;
  assign framing_error_o = rx_ferr_q;
  assign led_rx          = (led_rx_cnt_q != '0);
  assign led_tx          = (led_tx_cnt_q != '0);

endmodule

// File: tb/tb_uart_flow_echo.sv
module tb_uart_flow_echo;

  localparam int CPB  = 4;
  localparam int DB   = 3;
  localparam int XOFF = 6;
  localparam int XON  = 2;
  localparam int LEDC = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          uart_rx = 1'b1;
  logic          uart_tx;
  logic [DB:0]   fill_o;
  logic          overflow_o;
  logic          framing_error_o;
  logic          led_rx;
  logic          led_tx;

  uart_flow_echo #(
    .CLOCKS_PER_BAUD(CPB),
    .DEPTH_BITS(DB),
    .XOFF_LEVEL(XOFF),
    .XON_LEVEL(XON),
    .CORK_CHAR(8'h65),
    .UNCORK_CHAR(8'h7A),
    .LED_CYCLES(LEDC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .uart_rx(uart_rx),
    .uart_tx(uart_tx),
    .fill_o(fill_o),
    .overflow_o(overflow_o),
    .framing_error_o(framing_error_o),
    .led_rx(led_rx),
    .led_tx(led_tx)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         start_cyc[$];
  int         frames = 0;
  bit         mon_busy = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       exp_echo;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic b);
    uart_rx = b;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  // One 8N1 frame followed by one bit-time of idle line.
  task automatic send_rx(input logic [7:0] d, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    drive_bit(1'b1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    uart_rx = 1'b1;
    exp_q.delete();
    start_cyc.delete();
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      if (exp_q.size() == 0 && !mon_busy) break;
    end
    check("drain_remaining", exp_q.size(), 0);
  endtask

  // Long enough for any stray frame to complete and be flagged by the monitor.
  task automatic settle();
    repeat (12 * CPB) @(negedge clock);
    check("settle_line_idle", uart_tx, 1'b1);
  endtask

  // TX decoder, sampled on the falling edge; every completed frame is
  // checked against the head of the expected queue.
  task automatic tx_monitor();
    int         n;
    logic [7:0] sh;
    logic       ok;
    logic [7:0] e;
    n  = 0;
    sh = '0;
    ok = 1'b1;
    forever begin
      @(negedge clock);
      if (reset) begin
        mon_busy = 1'b0;
      end else if (!mon_busy) begin
        if (uart_tx === 1'b0) begin
          mon_busy = 1'b1;
          n  = 0;
          ok = 1'b1;
          start_cyc.push_back(cyc);
        end
      end else begin
        n++;
        if (n == CPB - 1 && uart_tx !== 1'b0) ok = 1'b0;
        if (n >= CPB + 1 && n <= 8 * CPB + 1 && ((n - 1) % CPB) == 0)
          sh = {uart_tx, sh[7:1]};
        if ((n == 9 * CPB + 1 || n == 10 * CPB - 1) && uart_tx !== 1'b1) ok = 1'b0;
        if (n == 10 * CPB - 1) begin
          mon_busy = 1'b0;
          frames++;
          if (exp_q.size() == 0) begin
            check("tx_unexpected_frame", {23'd0, ok, sh}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("tx_frame", {23'd0, ok, sh}, {23'd0, 1'b1, e});
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    int f0;

    vecs[0] = '{8'h00, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{8'hFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{8'h55, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h96, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'h7E, 1'b1, 1'b1, 1'b1};

    fork
      tx_monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst_uart_tx", uart_tx, 1'b1);
    check("rst_fill", fill_o, 0);
    check("rst_overflow", overflow_o, 1'b0);
    check("rst_framing", framing_error_o, 1'b0);
    check("rst_led_rx", led_rx, 1'b0);
    check("rst_led_tx", led_tx, 1'b0);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;

    // Single echo with LED stretch timing
    exp_q.push_back(8'hA5);
    fork
      send_rx(8'hA5, 1'b1);
    join_none
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (uart_tx === 1'b0) break;
    end
    check("echo_start_seen", uart_tx, 1'b0);
    check("led_rx_active", led_rx, 1'b1);
    repeat (LEDC - 1) @(negedge clock);
    check("led_tx_last_cycle", led_tx, 1'b1);
    @(negedge clock);
    check("led_tx_expired", led_tx, 1'b0);
    wait_drain(400);
    settle();
    check("leds_idle_rx", led_rx, 1'b0);
    check("leds_idle_tx", led_tx, 1'b0);

    // Table of frames including a bad stop bit
    do_reset();
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].exp_echo) exp_q.push_back(vecs[v].data);
      send_rx(vecs[v].data, vecs[v].stop);
      check($sformatf("vec%0d_framing", v), framing_error_o, vecs[v].exp_ferr);
      check($sformatf("vec%0d_fill", v), fill_o, 0);
      check($sformatf("vec%0d_overflow", v), overflow_o, 1'b0);
    end
    wait_drain(600);
    settle();

    // One-clock glitch on the line
    do_reset();
    f0 = frames;
    uart_rx = 1'b0;
    @(posedge clock);
    #1;
    uart_rx = 1'b1;
    repeat (60) @(negedge clock);
    check("glitch_fill", fill_o, 0);
    check("glitch_framing", framing_error_o, 1'b0);
    check("glitch_frames", frames - f0, 0);

    // Cork, XOFF at fill 6, uncork, drain with XON at fill 2
    do_reset();
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h65);
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'h30 + 8'(i));
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h36);
    exp_q.push_back(8'h7A);
    send_rx(8'h65, 1'b1);
    for (int i = 1; i <= 6; i++) send_rx(8'h30 + 8'(i), 1'b1);
    check("cork_fill_7", fill_o, 7);
    send_rx(8'h7A, 1'b1);
    wait_drain(2000);
    settle();
    check("cork_frame_count", start_cyc.size(), 10);
    if (start_cyc.size() >= 3)
      check("back_to_back_period", start_cyc[2] - start_cyc[1], 10 * CPB);
    check("cork_end_fill", fill_o, 0);
    check("cork_end_overflow", overflow_o, 1'b0);

    // Overflow while corked; ninth byte and dropped uncork char never appear
    do_reset();
    exp_q.push_back(8'h13);
    exp_q.push_back(8'h65);
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'h40 + 8'(i));
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h46);
    exp_q.push_back(8'h47);
    send_rx(8'h65, 1'b1);
    for (int i = 1; i <= 7; i++) send_rx(8'h40 + 8'(i), 1'b1);
    check("ovf_before_fill", fill_o, 8);
    check("ovf_before_flag", overflow_o, 1'b0);
    send_rx(8'h48, 1'b1);
    check("ovf_fill_full", fill_o, 8);
    check("ovf_flag_set", overflow_o, 1'b1);
    send_rx(8'h7A, 1'b1);
    wait_drain(2000);
    settle();
    check("ovf_flag_sticky", overflow_o, 1'b1);
    check("ovf_end_fill", fill_o, 0);

    // Reset in the middle of a TX frame
    do_reset();
    send_rx(8'h3C, 1'b0);
    send_rx(8'h5A, 1'b1);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (uart_tx === 1'b0) break;
    end
    check("midrst_frame_started", uart_tx, 1'b0);
    repeat (10) @(negedge clock);
    check("midrst_pre_framing", framing_error_o, 1'b1);
    check("midrst_pre_led_tx", led_tx, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_uart_tx", uart_tx, 1'b1);
    check("midrst_fill", fill_o, 0);
    check("midrst_overflow", overflow_o, 1'b0);
    check("midrst_framing", framing_error_o, 1'b0);
    check("midrst_led_rx", led_rx, 1'b0);
    check("midrst_led_tx", led_tx, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 30 * CPB; i++) begin
      @(negedge clock);
      if (uart_tx !== 1'b1) lows++;
    end
    check("midrst_no_resume", lows, 0);
    check("midrst_post_fill", fill_o, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
